uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Byte queue placed directly upstream of the UART transmitter.
- Accepts bytes from a producer (switch/button logic, or the receiver for loopback) at any rate and stores them in a circular FIFO.
- Drains the FIFO one byte at a time into the transmitter using its send/busy handshake, so a burst of writes is transmitted back-to-back without the producer waiting on the transmitter.

Parameters:
- DEPTH, 16, number of byte entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; one byte accepted per cycle it is high and the FIFO is not full.
- wr_data  input  8  byte to enqueue; sampled when wr_en is high.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is dropped.
- tx_send  output  1  send request to the transmitter.
- tx_din  output  8  byte presented to the transmitter; held stable while tx_send is high.
- tx_busy  input  1  transmitter busy flag.

Behaviour:
Clocking and reset
- Clock is clk; reset is rst, synchronous and active-high.
- While rst is high at a clock edge: rd_ptr=0, wr_ptr=0, count=0, state=IDLE, tx_din=8'h00, overflow=0.
- Reset outputs: empty=1, full=0, tx_send=0.

Reset mid-operation
- All queued bytes are discarded.
- tx_send is low from the first post-reset cycle, including when reset arrives in SEND.
- The transmitter is reset separately; this block does not wait on it.

FIFO
- full = (count==DEPTH); empty = (count==0). Both are decoded from the registered count.
- Write is accepted when wr_en && !full. mem[wr_ptr] <= wr_data, and wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Write with full=1 is dropped: memory and pointers unchanged, overflow=1 for the following cycle only.
  - This applies even if a pop happens in the same cycle; full is evaluated before the edge.
- A pop occurs only in state LOAD: tx_din <= mem[rd_ptr], and rd_ptr increments modulo DEPTH.
- Count update on an accepted write and/or a pop:
  - write and pop in the same cycle: count unchanged;
  - write only: count+1;
  - pop only: count-1.
- count never exceeds DEPTH and never underflows; a pop is impossible when empty.

Drain FSM (states IDLE, LOAD, SEND, WAIT_DONE)
- IDLE: tx_send=0. If !empty && !tx_busy, go to LOAD; otherwise stay.
- LOAD: single cycle. Pop the head byte into tx_din, then go to SEND.
- SEND: tx_send=1 and tx_din held. When tx_busy=1 is sampled, go to WAIT_DONE.
  - No timeout; tx_send stays high until busy is seen.
- WAIT_DONE: tx_send=0. When tx_busy=0 is sampled, go to IDLE.

Output timing and ordering
- tx_send is a decode of state==SEND; it is glitch-free because state is registered.
- Latency: a write accepted at edge E0 into an empty FIFO with state=IDLE and tx_busy=0 gives LOAD after E1 and tx_send high after E2.
- Minimum spacing between successive tx_send rising edges is 3 cycles plus the transmitter's busy time.
- Bytes leave in write order. tx_din changes only in LOAD.

Decomposition:
- Shared package uart_pkg holds:
  - enum typedef tx_buf_state_t {IDLE, LOAD, SEND, WAIT_DONE};
  - localparam DEFAULT_TX_DEPTH=16;
  - a byte_t typedef (logic [7:0]).
- One natural sub-module: sync_fifo (DEPTH, WIDTH=8).
  - Holds storage, pointers, count, full, empty and overflow.
  - Has push/pop/dout ports.
  - Instantiated once; the FSM stays in uart_tx_buffer.

Test Plan:
- Reset then idle, tx_busy=0 -> empty=1, full=0, count=0, tx_send=0 for 20 cycles.
- Write 8'hA5 with tx_busy=0 -> tx_send high 2 cycles after the write edge with tx_din=8'hA5. Model busy high 3 cycles after send, held 10 cycles. Expect tx_send low the cycle after busy is sampled, and count back to 0.
- Burst-write 8'h01..8'h05 on consecutive cycles, with the busy model above -> five sends in order 01,02,03,04,05. count peaks at 5 (or 4 if the first pop overlaps a write).
- Hold tx_busy=1, write DEPTH+2 bytes -> full=1 after 16 writes, count=16, and overflow pulses exactly twice. Release busy: 16 bytes are sent, the last one being the 16th byte written, and the 17th/18th never appear.
- Fill to 16 with tx_busy=1, release busy and write while the LOAD pop occurs -> the write is dropped (overflow=1) and count=15 after the edge. Then write at count=15 in the same cycle as a later pop -> count unchanged and the byte is accepted.
- Assert rst for 1 cycle while in SEND with 3 bytes queued -> tx_send=0 and count=0 next cycle. Then write 8'h3C: it is the next byte sent, with wr_ptr/rd_ptr wrap exercised by 20 further writes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int DEFAULT_TX_DEPTH = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE
    } tx_buf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular single-clock FIFO with a registered read port that updates only on pop.
// A write into a full FIFO is dropped and reported by a one-cycle overflow pulse.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] dout_q;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count, so a same-cycle pop never frees room for a write.
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign dout     = dout_q;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push && full;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (pop_ok) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue feeding a UART transmitter: bytes are buffered in a FIFO and
// drained one at a time through the transmitter's send/busy handshake.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_TX_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        tx_send,
    output logic [7:0]  tx_din,
    input  logic        tx_busy
);

    tx_buf_state_t state_q, state_d;
    logic          pop;
    byte_t         fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // The FIFO read register doubles as the transmitter data hold, so it only moves in LOAD.
    assign tx_din = fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND;
            end
            SEND: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_send = (state_q == SEND);
        pop     = (state_q == LOAD);
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer with a simple transmitter busy model.
module tb_uart_tx_buffer;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic        tx_send;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic        busy_force;
    logic        busy_model;

    int    n_checks = 0;
    int    n_fail   = 0;
    byte_t sent_q[$];
    bit    model_active = 1'b0;

    assign tx_busy = busy_force | busy_model;

    uart_tx_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_send  (tx_send),
        .tx_din   (tx_din),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter: latch the byte on send, raise busy 3 cycles later for 10 cycles.
    initial begin
        busy_model = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send) begin
                model_active = 1'b1;
                sent_q.push_back(tx_din);
                repeat (3) @(posedge clk);
                #1 busy_model = 1'b1;
                repeat (10) @(posedge clk);
                #1 busy_model = 1'b0;
                model_active = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input byte_t d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k = 0;
        while (sent_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check("sent_count", sent_q.size(), n);
    endtask

    task automatic wait_quiet(input int budget);
        int k = 0;
        while (!(dut.state_q == IDLE && !model_active && !tx_busy && empty) && k < budget) begin
            cyc();
            k++;
        end
        check("quiet_reached", (k < budget), 1);
    endtask

    initial begin
        int k;
        int peak;
        int ov;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int peak;
        int ov;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        busy_force = 1'b0;
        cyc(2);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_empty", empty, 1);
            check("idle_full", full, 0);
            check("idle_count", count, 0);
            check("idle_send", tx_send, 0);
        end
        check("idle_overflow", overflow, 0);
        check("idle_din", tx_din, 8'h00);

        // Single byte latency and handshake
        sent_q.delete();
        write_byte(8'hA5);
        check("a5_count_e0", count, 1);
        check("a5_send_e0", tx_send, 0);
        cyc();
        check("a5_send_e1", tx_send, 0);
        check("a5_count_e1", count, 1);
        cyc();
        check("a5_send_e2", tx_send, 1);
        check("a5_din_e2", tx_din, 8'hA5);
        check("a5_count_e2", count, 0);
        k = 0;
        while (!tx_busy && k < 20) begin
            cyc();
            k++;
        end
        check("a5_busy_seen", tx_busy, 1);
        check("a5_send_held", tx_send, 1);
        cyc();
        check("a5_send_drop", tx_send, 0);
        check("a5_count_end", count, 0);
        wait_sent(1, 100);
        check("a5_byte", sent_q[0], 8'hA5);
        wait_quiet(100);

        // Burst of five
        sent_q.delete();
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            write_byte(byte_t'(i));
            if (int'(count) > peak) peak = int'(count);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (int'(count) > peak) peak = int'(count);
        end
        check("burst_peak", peak, 4);
        wait_sent(5, 400);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_byte%0d", i), sent_q[i], i + 1);
        end
        wait_quiet(100);

        // Overfill while the transmitter is busy
        sent_q.delete();
        busy_force = 1'b1;
        ov = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_byte(byte_t'(8'h40 + i));
            if (overflow) ov++;
            if (i == DEPTH - 1) begin
                check("fill_full", full, 1);
                check("fill_count", count, 16);
            end
        end
        cyc();
        if (overflow) ov++;
        check("ovf_pulses", ov, 2);
        check("ovf_count", count, 16);
        busy_force = 1'b0;
        wait_sent(16, 800);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_byte%0d", i), sent_q[i], 8'h40 + i);
        end
        cyc(40);
        check("fill_no_extra", sent_q.size(), 16);
        wait_quiet(100);

        // Write while full during a pop, then write at 15 during a pop
        sent_q.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) begin
            write_byte(byte_t'(8'h60 + i));
        end
        check("pop_full", full, 1);
        busy_force = 1'b0;
        cyc();
        check("pop_in_load", (dut.state_q == LOAD), 1);
        write_byte(8'h77);
        check("pop_drop_ovf", overflow, 1);
        check("pop_drop_count", count, 15);
        k = 0;
        while (dut.state_q != LOAD && k < 60) begin
            cyc();
            k++;
        end
        check("pop2_load_found", (k < 60), 1);
        check("pop2_count_pre", count, 15);
        write_byte(8'h7A);
        check("pop2_count_post", count, 15);
        check("pop2_no_ovf", overflow, 0);
        wait_sent(17, 800);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pop_byte%0d", i), sent_q[i], 8'h60 + i);
        end
        check("pop_byte16", sent_q[16], 8'h7A);
        wait_quiet(100);

        // Reset while in SEND with 3 bytes queued
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_byte(byte_t'(8'h90 + i));
        end
        busy_force = 1'b0;
        k = 0;
        while (!tx_send && k < 20) begin
            cyc();
            k++;
        end
        check("rst_in_send", tx_send, 1);
        check("rst_queued", count, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_send_low", tx_send, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        k = 0;
        while (model_active && k < 40) begin
            cyc();
            k++;
        end
        sent_q.delete();
        write_byte(8'h3C);
        wait_sent(1, 100);
        check("rst_next_byte", sent_q[0], 8'h3C);
        wait_quiet(100);

        // Pointer wrap: 20 more bytes in two batches
        sent_q.delete();
        for (int b = 0; b < 2; b++) begin
            busy_force = 1'b1;
            for (int i = 0; i < 10; i++) begin
                write_byte(byte_t'(8'hB0 + b * 10 + i));
            end
            busy_force = 1'b0;
            wait_sent((b + 1) * 10, 600);
            wait_quiet(100);
        end
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_byte%0d", i), sent_q[i], 8'hB0 + i);
        end
        check("wrap_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
